// File: rtl/fetch_stage_pkg.sv
// Shared core definitions used by the fetch stage: the canonical NOP and the
// fetch FSM state encodings.
package fetch_stage_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHeld = 2'd2
  } fetch_state_e;

  // Fetch always targets word boundaries; low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous-read
// instruction memory and presents {pc, inst, inst_valid} to decode, handling
// boot warm-up, stalls, redirects and a delivered-instruction counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] inst_cnt,
  output logic        fetch_fault
);

  logic [31:0]  fetch_pc_q;
  logic [31:0]  next_pc;
  logic [31:0]  hold_inst_q;
  logic [31:0]  inst_cnt_q;
  logic         fetch_fault_q;
  fetch_state_e state_q;

  // Next fetch address, in priority order: reset, redirect, boot re-issue, stall, sequential.
  always_comb begin
    next_pc = fetch_pc_q + 32'd4;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (redirect) begin
      next_pc = align_word(redirect_pc);
    end else if (state_q == StBoot || stall) begin
      next_pc = fetch_pc_q;
    end
  end

  assign imem_addr = next_pc;
  // Memory read is suppressed only while the current word is being held.
  assign imem_en   = rst | redirect | (state_q == StBoot) | ~stall;

  // Decode-facing instruction: live memory data in RUN, held copy in HELD, bubble in BOOT.
  always_comb begin
    inst       = INST_NOP;
    inst_valid = 1'b0;
    case (state_q)
      StRun: begin
        inst       = imem_dout;
        inst_valid = 1'b1;
      end
      StHeld: begin
        inst       = hold_inst_q;
        inst_valid = 1'b1;
      end
      default: begin
        inst       = INST_NOP;
        inst_valid = 1'b0;
      end
    endcase
  end

  // Fetch PC follows next_pc every cycle; FSM and hold register track boot/stall/redirect.
  always_ff @(posedge clk) begin
    fetch_pc_q <= next_pc;
    if (rst) begin
      state_q     <= StBoot;
      hold_inst_q <= INST_NOP;
    end else if (redirect) begin
      state_q <= StRun;
    end else begin
      case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          if (stall) begin
            // Memory read is disabled from here on, so capture the word now.
            hold_inst_q <= imem_dout;
            state_q     <= StHeld;
          end
        end
        StHeld: begin
          if (!stall) state_q <= StRun;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  // Delivered-instruction counter and sticky misaligned-redirect flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_cnt_q    <= 32'd0;
      fetch_fault_q <= 1'b0;
    end else begin
      if (inst_valid && !stall && !redirect) inst_cnt_q <= inst_cnt_q + 32'd1;
      if (redirect && (redirect_pc[1:0] != 2'b00)) fetch_fault_q <= 1'b1;
    end
  end

  assign pc          = fetch_pc_q;
  assign inst_cnt    = inst_cnt_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, counter-wrap
// force, then randomized traffic against a cycle-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout = 32'd0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_cnt;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_dout   (imem_dout),
    .pc          (pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_cnt    (inst_cnt),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of address, so any target is readable.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Synchronous-read instruction memory with read enable.
  always @(posedge clk) begin
    if (imem_en) imem_dout <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what decode sees this cycle.
  bit          m_known = 0;
  bit          m_boot;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_fault;

  // Address the model expects to be shown after the coming edge.
  function automatic logic [31:0] model_next_pc(input bit r, s, d, input logic [31:0] t);
    if (r) return RESET_PC;
    if (d) return {t[31:2], 2'b00};
    if (m_boot || s) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic drive(input bit r, s, d, input logic [31:0] t, input bit fc);
    @(negedge clk);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    if (fc) begin
      force dut.inst_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.inst_cnt_q;
      m_cnt = 32'hFFFF_FFFF;
    end
    #1;
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
      chk("inst", inst, m_valid ? mem_word(m_pc) : NOP);
      chk("inst_cnt", inst_cnt, m_cnt);
      chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    end
    if (m_known || r) begin
      chk("imem_addr", imem_addr, model_next_pc(r, s, d, t));
      chk("imem_en", {31'd0, imem_en}, {31'd0, (r | d | (m_known & m_boot) | ~s)});
    end
  endtask

  task automatic advance();
    logic [31:0] npc;
    @(posedge clk);
    if (rst) begin
      m_known = 1; m_boot = 1; m_valid = 0; m_pc = RESET_PC; m_cnt = 0; m_fault = 0;
    end else if (m_known) begin
      npc = model_next_pc(0, stall, redirect, redirect_pc);
      if (m_valid && !stall && !redirect) m_cnt = m_cnt + 32'd1;
      if (redirect && redirect_pc[1:0] != 2'b00) m_fault = 1;
      m_pc = npc; m_valid = 1; m_boot = 0;
    end
  endtask

  typedef struct {
    bit          r, s, d;
    logic [31:0] t;
    bit          chk;
    logic [31:0] pc;
    bit          valid;
    logic [31:0] cnt;
    bit          fault;
    bit          en;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input bit r, s, d, input logic [31:0] t, input bit c,
                              input logic [31:0] p, input bit v, input logic [31:0] n,
                              input bit f, input bit e);
    vec_t x;
    x.r = r; x.s = s; x.d = d; x.t = t; x.chk = c;
    x.pc = p; x.valid = v; x.cnt = n; x.fault = f; x.en = e;
    return x;
  endfunction

  initial begin
    // Hand-derived expectations for the directed scenarios.
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 1, 32'h4000_0000, 0, 0, 0, 1);        // boot bubble
    vecs[4]  = mk(0, 0, 0, 0, 1, 32'h4000_0000, 1, 0, 0, 1);        // first valid
    vecs[5]  = mk(0, 0, 0, 0, 1, 32'h4000_0004, 1, 1, 0, 1);
    vecs[6]  = mk(0, 1, 0, 0, 1, 32'h4000_0008, 1, 2, 0, 0);        // stall starts
    vecs[7]  = mk(0, 1, 0, 0, 1, 32'h4000_0008, 1, 2, 0, 0);        // held
    vecs[8]  = mk(0, 1, 0, 0, 1, 32'h4000_0008, 1, 2, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1, 32'h4000_0008, 1, 2, 0, 1);        // stall drops
    vecs[10] = mk(0, 0, 0, 0, 1, 32'h4000_000C, 1, 3, 0, 1);
    vecs[11] = mk(0, 1, 0, 0, 1, 32'h4000_0010, 1, 4, 0, 0);
    vecs[12] = mk(0, 1, 1, 32'h1000_0040, 1, 32'h4000_0010, 1, 4, 0, 1); // redirect in HELD
    vecs[13] = mk(0, 0, 0, 0, 1, 32'h1000_0040, 1, 4, 0, 1);
    vecs[14] = mk(0, 0, 1, 32'h1000_0042, 1, 32'h1000_0044, 1, 5, 0, 1); // misaligned
    vecs[15] = mk(0, 0, 0, 0, 1, 32'h1000_0040, 1, 5, 1, 1);
    vecs[16] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h1000_0044, 1, 6, 1, 1);
    vecs[17] = mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 6, 1, 1);
    vecs[18] = mk(0, 0, 0, 0, 1, 32'h0000_0000, 1, 7, 1, 1);        // pc wrap
    vecs[19] = mk(0, 1, 0, 0, 1, 32'h0000_0004, 1, 8, 1, 0);
    vecs[20] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);                    // reset mid-stall
    vecs[21] = mk(0, 1, 0, 0, 1, 32'h4000_0000, 0, 0, 0, 1);        // boot ignores stall
    vecs[22] = mk(0, 0, 0, 0, 1, 32'h4000_0000, 1, 0, 0, 1);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].t, 0);
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d.pc", i), pc, vecs[i].pc);
        chk($sformatf("vec%0d.valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].valid});
        chk($sformatf("vec%0d.inst", i), inst,
            vecs[i].valid ? mem_word(vecs[i].pc) : NOP);
        chk($sformatf("vec%0d.cnt", i), inst_cnt, vecs[i].cnt);
        chk($sformatf("vec%0d.fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].fault});
        chk($sformatf("vec%0d.en", i), {31'd0, imem_en}, {31'd0, vecs[i].en});
      end
      advance();
    end

    // Fault stays set across free-running cycles until reset.
    drive(0, 0, 1, 32'h2000_0001, 0);
    advance();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
      advance();
    end

    // Counter wrap: preload all-ones and accept one instruction.
    drive(0, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0);
    chk("cnt_wrap", inst_cnt, 32'd0);
    advance();

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 400; i++) begin
      bit          r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 35);
      d = ($urandom_range(0, 99) < 12);
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      drive(r, s, d, t, 0);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
